// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block geometry, padding constants, padder FSM
// states and the initial hash value used by the compression core.
package sha256_pkg;

  localparam int BLOCK_W         = 512;
  localparam int WORD_W          = 32;
  localparam int LEN_FIELD_W     = 64;
  localparam int WORDS_PER_BLOCK = 16;

  localparam logic [WORD_W-1:0] PAD_MARKER = 32'h8000_0000;

  localparam logic [0:7][WORD_W-1:0] SHA256_IV = {
    32'h6a09_e667, 32'hbb67_ae85, 32'h3c6e_f372, 32'ha54f_f53a,
    32'h510e_527f, 32'h9b05_688c, 32'h1f83_d9ab, 32'h5be0_cd19
  };

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    ZERO = 2'd2,
    EMIT = 2'd3
  } padder_state_e;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-stream input and padded-block output of the message padder.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic [WORD_W-1:0]  in_data;
  logic [2:0]         in_bytes;
  logic               in_last;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] block_out;
  logic               block_valid;
  logic               block_ready;
  logic               block_last;

  modport master (
    output in_data, in_bytes, in_last, in_valid, block_ready,
    input  in_ready, block_out, block_valid, block_last
  );

  modport slave (
    input  in_data, in_bytes, in_last, in_valid, block_ready,
    output in_ready, block_out, block_valid, block_last
  );

endinterface

// File: rtl/sha256_byte_mask.sv
// Builds the tail word of a message: keeps the first in_bytes bytes, puts the
// 0x80 marker right after them and zeroes the rest. Full words pass through.
module sha256_byte_mask
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        nbytes,
  output logic [WORD_W-1:0] word
);

  // Select the masked word for the number of valid leading bytes
  always_comb begin
    word = data;
    case (nbytes)
      3'd0:    word = PAD_MARKER;
      3'd1:    word = {data[31:24], 24'h80_0000};
      3'd2:    word = {data[31:16], 16'h8000};
      3'd3:    word = {data[31:8], 8'h80};
      default: word = data;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: collects 32-bit words into a 16-word block,
// appends marker, zero fill and bit length, and hands blocks to the core.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  sha256_msg_padder_if.slave  bus
);

  padder_state_e                      state_r, state_nx;
  logic [3:0]                         slot_r, slot_nx;
  logic [LEN_W-1:0]                   bitlen_r, bitlen_nx;
  logic [0:WORDS_PER_BLOCK-1][WORD_W-1:0] buf_r;
  logic                               ready_r, valid_r;
  logic                               last_r, last_nx;
  logic                               spill_r, spill_nx;
  logic                               len_pend_r, len_pend_nx;
  logic                               pad_pend_r, pad_pend_nx;
  logic                               wr_en_s, len_wr_s, fire_s, full_s;
  logic [WORD_W-1:0]                  wr_data_s, tail_word_s;
  logic [2:0]                         eff_bytes_s;
  logic [LEN_FIELD_W-1:0]             len_field_s;

  sha256_byte_mask u_mask (
    .data   (bus.in_data),
    .nbytes (bus.in_bytes),
    .word   (tail_word_s)
  );

  assign fire_s      = bus.in_valid & ready_r;
  assign eff_bytes_s = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
  assign full_s      = (eff_bytes_s == 3'd4);
  assign len_field_s = LEN_FIELD_W'(bitlen_r);

  assign bus.in_ready    = ready_r;
  assign bus.block_valid = valid_r;
  assign bus.block_last  = last_r;
  assign bus.block_out   = buf_r;

  // Next-state, slot/length bookkeeping and buffer write selection
  always_comb begin
    state_nx    = state_r;
    slot_nx     = slot_r;
    bitlen_nx   = bitlen_r;
    last_nx     = last_r;
    spill_nx    = spill_r;
    len_pend_nx = len_pend_r;
    pad_pend_nx = pad_pend_r;
    wr_en_s     = 1'b0;
    len_wr_s    = 1'b0;
    wr_data_s   = tail_word_s;
    case (state_r)
      FILL: begin
        if (fire_s) begin
          wr_en_s   = 1'b1;
          bitlen_nx = bitlen_r + LEN_W'({eff_bytes_s, 3'b000});
          // A short word carries the marker; it always ends the message
          if (!full_s) begin
            if (slot_r == 4'd15) begin
              state_nx    = EMIT;
              last_nx     = 1'b0;
              len_pend_nx = 1'b1;
            end else begin
              state_nx = ZERO;
              slot_nx  = slot_r + 4'd1;
              spill_nx = (slot_r == 4'd14);
            end
          end else if (bus.in_last) begin
            if (slot_r == 4'd15) begin
              state_nx    = EMIT;
              last_nx     = 1'b0;
              pad_pend_nx = 1'b1;
            end else begin
              state_nx = PAD;
              slot_nx  = slot_r + 4'd1;
            end
          end else if (slot_r == 4'd15) begin
            state_nx = EMIT;
            last_nx  = 1'b0;
          end else begin
            slot_nx = slot_r + 4'd1;
          end
        end else begin
          state_nx = FILL;
        end
      end
      PAD: begin
        wr_en_s     = 1'b1;
        wr_data_s   = PAD_MARKER;
        pad_pend_nx = 1'b0;
        if (slot_r == 4'd15) begin
          state_nx    = EMIT;
          last_nx     = 1'b0;
          len_pend_nx = 1'b1;
        end else begin
          state_nx = ZERO;
          slot_nx  = slot_r + 4'd1;
          spill_nx = (slot_r == 4'd14);
        end
      end
      ZERO: begin
        // Length goes into words 14/15 unless the marker spilled past word 13
        if (!spill_r && (slot_r == 4'd14)) begin
          len_wr_s = 1'b1;
          state_nx = EMIT;
          last_nx  = 1'b1;
        end else begin
          wr_en_s   = 1'b1;
          wr_data_s = {WORD_W{1'b0}};
          if (slot_r == 4'd15) begin
            state_nx    = EMIT;
            last_nx     = 1'b0;
            len_pend_nx = 1'b1;
            spill_nx    = 1'b0;
          end else begin
            slot_nx = slot_r + 4'd1;
          end
        end
      end
      EMIT: begin
        if (valid_r && bus.block_ready) begin
          slot_nx = 4'd0;
          last_nx = 1'b0;
          if (last_r) begin
            bitlen_nx = {LEN_W{1'b0}};
            state_nx  = FILL;
          end else if (pad_pend_r) begin
            state_nx = PAD;
          end else if (len_pend_r) begin
            state_nx    = ZERO;
            len_pend_nx = 1'b0;
            spill_nx    = 1'b0;
          end else begin
            state_nx = FILL;
          end
        end else begin
          state_nx = EMIT;
        end
      end
      default: begin
        state_nx = FILL;
      end
    endcase
  end

  // Control state, length counter and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= FILL;
      slot_r     <= 4'd0;
      bitlen_r   <= {LEN_W{1'b0}};
      ready_r    <= 1'b0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      spill_r    <= 1'b0;
      len_pend_r <= 1'b0;
      pad_pend_r <= 1'b0;
    end else begin
      state_r    <= state_nx;
      slot_r     <= slot_nx;
      bitlen_r   <= bitlen_nx;
      ready_r    <= (state_nx == FILL);
      valid_r    <= (state_nx == EMIT);
      last_r     <= last_nx;
      spill_r    <= spill_nx;
      len_pend_r <= len_pend_nx;
      pad_pend_r <= pad_pend_nx;
    end
  end

  // Block buffer: one word per cycle, or both length words at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_r <= '0;
    end else if (wr_en_s) begin
      buf_r[slot_r] <= wr_data_s;
    end else if (len_wr_s) begin
      buf_r[14] <= len_field_s[63:32];
      buf_r[15] <= len_field_s[31:0];
    end else begin
      buf_r <= buf_r;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: table of message lengths checked
// against a byte-level FIPS 180-4 padding model, plus stall and reset cases.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic reset;

  sha256_msg_padder_if bus();

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbytes;
    int          exp_blocks;
    logic [63:0] exp_len;
    int          mblk;
    int          mword;
    logic [31:0] mval;
  } vec_t;

  vec_t        vecs [9];
  int          tests = 0;
  int          fails = 0;
  logic [511:0] got_blk [0:3];
  logic        got_last [0:3];
  int          got_n;

  localparam logic [511:0] ABC_BLOCK = {32'h6162_6380, 416'h0, 64'h18};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] model_block(input int n, input int b);
    logic [511:0] r;
    logic [63:0]  len;
    int nblk, total, idx;
    nblk  = (n + 8) / 64 + 1;
    total = nblk * 64;
    len   = 64'(n) * 64'd8;
    r     = '0;
    for (int k = 0; k < 64; k++) begin
      idx = b * 64 + k;
      if (idx < n)                r[511-8*k -: 8] = 8'(idx + 97);
      else if (idx == n)          r[511-8*k -: 8] = 8'h80;
      else if (idx >= total - 8)  r[511-8*k -: 8] = 8'(len >> (8 * (total - 1 - idx)));
      else                        r[511-8*k -: 8] = 8'h00;
    end
    return r;
  endfunction

  // Called at a negedge; drives message bytes 'a','b','c',... word by word
  task automatic send_msg(input int n, input int stop_after);
    int nw, nb, t;
    logic [31:0] d;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw && w < stop_after; w++) begin
      d  = 32'h0;
      nb = (w == nw - 1) ? n - 4 * w : 4;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) d[31-8*k -: 8] = 8'(4 * w + k + 97);
      bus.in_data  = d;
      bus.in_bytes = 3'(nb);
      bus.in_last  = (w == nw - 1);
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (t >= 400) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: word %0d of %0d-byte msg never accepted", w, n);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic recv_blocks(input int nexp);
    int t;
    got_n = 0;
    for (int b = 0; b < nexp && b < 4; b++) begin
      t = 0;
      while (!bus.block_valid && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (t >= 400) begin
        tests++;
        fails++;
        $display("FAIL recv_timeout: block %0d never became valid", b);
        break;
      end
      got_blk[b]  = bus.block_out;
      got_last[b] = bus.block_last;
      got_n++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    bus.block_ready = 1'b1;
    fork
      send_msg(v.nbytes, 99);
      recv_blocks(v.exp_blocks);
    join
    check($sformatf("v%0d_nblocks", i), 512'(got_n), 512'(v.exp_blocks));
    for (int b = 0; b < got_n; b++) begin
      check($sformatf("v%0d_blk%0d", i, b), got_blk[b], model_block(v.nbytes, b));
      check($sformatf("v%0d_last%0d", i, b), 512'(got_last[b]), 512'(b == v.exp_blocks - 1));
    end
    if (got_n == v.exp_blocks) begin
      check($sformatf("v%0d_len", i), 512'(got_blk[got_n-1][63:0]), 512'(v.exp_len));
      check($sformatf("v%0d_marker", i), 512'(got_blk[v.mblk][511-32*v.mword -: 32]), 512'(v.mval));
    end else begin
      tests++;
      fails++;
      $display("FAIL v%0d_count: got %0d blocks expected %0d", i, got_n, v.exp_blocks);
    end
    check($sformatf("v%0d_ready_after", i), 512'(bus.in_ready), 512'(1'b1));
    check($sformatf("v%0d_valid_after", i), 512'(bus.block_valid), 512'(1'b0));
  endtask

  initial begin
    logic [511:0] cap;
    logic         stable;
    int           t;

    vecs[0] = '{3,   1, 64'h18,  0, 0,  32'h6162_6380};
    vecs[1] = '{0,   1, 64'h0,   0, 0,  32'h8000_0000};
    vecs[2] = '{55,  1, 64'h1B8, 0, 13, 32'h9596_9780};
    vecs[3] = '{56,  2, 64'h1C0, 0, 14, 32'h8000_0000};
    vecs[4] = '{64,  2, 64'h200, 1, 0,  32'h8000_0000};
    vecs[5] = '{5,   1, 64'h28,  0, 1,  32'h6580_0000};
    vecs[6] = '{62,  2, 64'h1F0, 0, 15, 32'h9D9E_8000};
    vecs[7] = '{59,  2, 64'h1D8, 0, 14, 32'h999A_9B80};
    vecs[8] = '{120, 3, 64'h3C0, 1, 14, 32'h8000_0000};

    reset           = 1'b0;
    bus.in_data     = 32'h0;
    bus.in_bytes    = 3'd0;
    bus.in_last     = 1'b0;
    bus.in_valid    = 1'b0;
    bus.block_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_block_out", bus.block_out, 512'h0);
    check("rst_valid", 512'(bus.block_valid), 512'h0);
    check("rst_last", 512'(bus.block_last), 512'h0);
    check("rst_ready", 512'(bus.in_ready), 512'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Consumer stalls 20 cycles: block and handshake outputs must hold
    bus.block_ready = 1'b0;
    send_msg(3, 99);
    t = 0;
    while (!bus.block_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("stall_valid_seen", 512'(bus.block_valid), 512'h1);
    cap    = bus.block_out;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.block_out !== cap || bus.block_valid !== 1'b1 ||
          bus.in_ready !== 1'b0 || bus.block_last !== 1'b1) stable = 1'b0;
    end
    check("stall_stable", 512'(stable), 512'h1);
    check("stall_block", cap, ABC_BLOCK);
    bus.block_ready = 1'b1;
    @(negedge clk);
    check("stall_released", 512'(bus.block_valid), 512'h0);

    // Back-to-back after the stalled message: length must restart from zero
    run_vec(0);

    // Reset in the middle of filling a block
    send_msg(40, 7);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_block_out", bus.block_out, 512'h0);
    check("midrst_valid", 512'(bus.block_valid), 512'h0);
    check("midrst_last", 512'(bus.block_last), 512'h0);
    check("midrst_ready", 512'(bus.in_ready), 512'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fork
      send_msg(3, 99);
      recv_blocks(1);
    join
    check("postrst_count", 512'(got_n), 512'h1);
    check("postrst_block", got_blk[0], ABC_BLOCK);
    check("postrst_last", 512'(got_last[0]), 512'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
